// File: rtl/dm_responder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// dm_responder
// Data-memory responder for the CPU's data port. It accepts one load or store
// at a time through a req/ready handshake and answers with a one-cycle ack a
// fixed number of cycles later. Misaligned or out-of-range accesses are still
// acked, with err set and no side effects.
//
// Ports
//   clk    rising-edge clock
//   rst    asynchronous reset, active-low
//   req    request valid, held with a stable payload until accepted
//   we     1 = store, 0 = load
//   addr   byte address; word index is addr[31:2]
//   be     byte enables for stores (be[0] -> bits 7:0)
//   wdata  store data
//   ready  idle and able to accept a request this cycle
//   ack    one-cycle response strobe
//   rdata  load data while ack=1 and err=0, otherwise 0
//   err    with ack: access was misaligned or beyond the array
// -----------------------------------------------------------------------------
module dm_responder #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W   = $clog2(LATENCY + 1);
    localparam logic [29:0] DEPTH_W = 30'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // Captured request
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [3:0]         be_q, be_d;
    logic [31:0]        wdata_q, wdata_d;

    // Registered outputs
    logic               ready_q, ready_d;
    logic               ack_q, ack_d;
    logic               err_q, err_d;
    logic [31:0]        rdata_q, rdata_d;

    // Storage: not reset, contents undefined until written
    logic [31:0]        mem_q [DEPTH];

    logic               addr_err_c;
    logic [IDX_W-1:0]   idx_d;
    logic [IDX_W-1:0]   idx_q;
    logic               mem_wr_c;

    // Misaligned or beyond the last word; high address bits never alias
    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:2] >= DEPTH_W);
    endfunction

    // State, captured request and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            ready_q <= 1'b1;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Next state, request capture and next output values
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    we_d    = we;
                    addr_d  = addr;
                    be_d    = be;
                    wdata_d = wdata;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = (LATENCY > 1) ? WAIT : RESP;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered, so they are derived from the next state and
        // the request that will be held during it. The array read happens on
        // the edge entering RESP, which never coincides with a store commit.
        idx_d      = addr_d[IDX_W+1:2];
        addr_err_c = addr_bad(addr_d);
        ready_d    = (state_d == IDLE);
        ack_d      = (state_d == RESP);
        err_d      = ack_d && addr_err_c;
        rdata_d    = (ack_d && !addr_err_c && !we_d) ? mem_q[idx_d] : '0;
    end

    // Store commits on the edge that ends RESP; a reset abort leaves IDLE
    assign idx_q    = addr_q[IDX_W+1:2];
    assign mem_wr_c = (state_q == RESP) && we_q && !err_q;

    always_ff @(posedge clk) begin
        if (mem_wr_c) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    assign ready = ready_q;
    assign ack   = ack_q;
    assign err   = err_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_dm_responder.sv
`timescale 1ns/1ps
// Bench for dm_responder: three instances (LATENCY 2, 4, 1) with DEPTH 256,
// expected responses queued at drive time and compared when ack appears.
module tb_dm_responder;

    localparam int unsigned DEPTH = 256;
    localparam int LAT0 = 2;
    localparam int LAT1 = 4;
    localparam int LAT2 = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_v   [3];
    logic        we_v    [3];
    logic [31:0] addr_v  [3];
    logic [3:0]  be_v    [3];
    logic [31:0] wdata_v [3];
    logic        ready_v [3];
    logic        ack_v   [3];
    logic [31:0] rdata_v [3];
    logic        err_v   [3];

    always #5 clk = ~clk;

    dm_responder #(.DEPTH(DEPTH), .LATENCY(LAT0)) u_dut0 (
        .clk(clk), .rst(rst), .req(req_v[0]), .we(we_v[0]), .addr(addr_v[0]),
        .be(be_v[0]), .wdata(wdata_v[0]), .ready(ready_v[0]), .ack(ack_v[0]),
        .rdata(rdata_v[0]), .err(err_v[0]));

    dm_responder #(.DEPTH(DEPTH), .LATENCY(LAT1)) u_dut1 (
        .clk(clk), .rst(rst), .req(req_v[1]), .we(we_v[1]), .addr(addr_v[1]),
        .be(be_v[1]), .wdata(wdata_v[1]), .ready(ready_v[1]), .ack(ack_v[1]),
        .rdata(rdata_v[1]), .err(err_v[1]));

    dm_responder #(.DEPTH(DEPTH), .LATENCY(LAT2)) u_dut2 (
        .clk(clk), .rst(rst), .req(req_v[2]), .we(we_v[2]), .addr(addr_v[2]),
        .be(be_v[2]), .wdata(wdata_v[2]), .ready(ready_v[2]), .ack(ack_v[2]),
        .rdata(rdata_v[2]), .err(err_v[2]));

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] mdl [3][DEPTH];
    exp_t        sb [$];

    function automatic logic exp_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH));
    endfunction

    // Compute the expected response from the model and queue it
    task automatic push_exp(input int d, input logic w, input logic [31:0] a,
                            input logic [3:0] b, input logic [31:0] wd);
        exp_t        e;
        logic [31:0] word;
        e.err   = exp_bad(a);
        e.rdata = '0;
        if (!e.err) begin
            word = mdl[d][a[9:2]];
            if (w) begin
                for (int i = 0; i < 4; i++) begin
                    if (b[i]) word[8*i +: 8] = wd[8*i +: 8];
                end
                mdl[d][a[9:2]] = word;
            end else begin
                e.rdata = word;
            end
        end
        sb.push_back(e);
    endtask

    // Drive one transaction, return what the DUT did (timing, err, rdata)
    task automatic run_txn(input int d, input logic w, input logic [31:0] a,
                           input logic [3:0] b, input logic [31:0] wd,
                           output int lat, output int busy, output logic o_err,
                           output logic [31:0] o_rdata, output logic o_idle_after);
        int waited;
        lat = -1; busy = 0; o_err = 1'b0; o_rdata = '0; o_idle_after = 1'b0;
        @(negedge clk);
        req_v[d] = 1'b1; we_v[d] = w; addr_v[d] = a; be_v[d] = b; wdata_v[d] = wd;
        push_exp(d, w, a, b, wd);
        waited = 0;
        while (ready_v[d] !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        @(negedge clk);
        // Request dropped and payload scrambled while busy
        req_v[d] = 1'b0; we_v[d] = ~w; addr_v[d] = ~a; be_v[d] = ~b; wdata_v[d] = ~wd;
        for (int k = 1; k <= 12; k++) begin
            if (ready_v[d] === 1'b0) busy++;
            if (ack_v[d] === 1'b1) begin
                lat = k; o_err = err_v[d]; o_rdata = rdata_v[d];
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        o_idle_after = (ready_v[d] === 1'b1) && (ack_v[d] === 1'b0);
    endtask

    task automatic test_reset();
        int acks;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (ready_v[d] !== 1'b1 || ack_v[d] !== 1'b0 || err_v[d] !== 1'b0 || rdata_v[d] !== 32'h0) begin
                errors++;
                $display("FAIL reset_state dut%0d: ready=%b ack=%b err=%b rdata=%h, want 1 0 0 00000000",
                         d, ready_v[d], ack_v[d], err_v[d], rdata_v[d]);
            end
        end
        rst = 1'b1;
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) if (ack_v[d] !== 1'b0 || ready_v[d] !== 1'b1) acks++;
        end
        checks++;
        if (acks != 0) begin
            errors++;
            $display("FAIL idle_no_ack: %0d cycles with ack or !ready, want 0", acks);
        end
    endtask

    task automatic test_latency_data();
        logic        tw [2] = '{1'b1, 1'b0};
        logic [31:0] td [2] = '{32'hDEADBEEF, 32'h0};
        int lat, busy; logic o_err, idle_ok; logic [31:0] o_rd; exp_t e;
        for (int i = 0; i < 2; i++) begin
            run_txn(0, tw[i], 32'h10, 4'b1111, td[i], lat, busy, o_err, o_rd, idle_ok);
            e = sb.pop_front();
            checks++;
            if (lat != LAT0 || busy != LAT0 || !idle_ok) begin
                errors++;
                $display("FAIL lat_data[%0d] timing: lat=%0d busy=%0d idle_after=%b, want lat=%0d busy=%0d idle_after=1",
                         i, lat, busy, idle_ok, LAT0, LAT0);
            end
            checks++;
            if (o_err !== e.err || o_rd !== e.rdata) begin
                errors++;
                $display("FAIL lat_data[%0d] resp: err=%b rdata=%h, want err=%b rdata=%h", i, o_err, o_rd, e.err, e.rdata);
            end
        end
    endtask

    task automatic test_byte_enables();
        logic        tw [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [3:0]  tb [5] = '{4'b1111, 4'b0101, 4'b0000, 4'b0000, 4'b1111};
        logic [31:0] td [5] = '{32'h11223344, 32'hAABBCCDD, 32'h0, 32'hFFFFFFFF, 32'h0};
        int lat, busy; logic o_err, idle_ok; logic [31:0] o_rd; exp_t e;
        for (int i = 0; i < 5; i++) begin
            run_txn(0, tw[i], 32'h10, tb[i], td[i], lat, busy, o_err, o_rd, idle_ok);
            e = sb.pop_front();
            checks++;
            if (lat != LAT0 || busy != LAT0 || !idle_ok) begin
                errors++;
                $display("FAIL byte_en[%0d] timing: lat=%0d busy=%0d idle_after=%b, want lat=%0d busy=%0d", i, lat, busy, idle_ok, LAT0, LAT0);
            end
            checks++;
            if (o_err !== e.err || o_rd !== e.rdata) begin
                errors++;
                $display("FAIL byte_en[%0d] resp: err=%b rdata=%h, want err=%b rdata=%h", i, o_err, o_rd, e.err, e.rdata);
            end
        end
    endtask

    task automatic test_errors();
        logic        tw [10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] ta [10] = '{32'h0, 32'h402, 32'h400, 32'h404, 32'h5, 32'h3,
                                 32'h3FC, 32'h3FC, 32'h8000_0000, 32'h0};
        logic [31:0] td [10] = '{32'hCAFEF00D, 32'h0BADBAD0, 32'h0, 32'h0BAD0BAD, 32'h0,
                                 32'h55555555, 32'h600DF00D, 32'h0, 32'h0, 32'h0};
        int lat, busy; logic o_err, idle_ok; logic [31:0] o_rd; exp_t e;
        for (int i = 0; i < 10; i++) begin
            run_txn(0, tw[i], ta[i], 4'b1111, td[i], lat, busy, o_err, o_rd, idle_ok);
            e = sb.pop_front();
            checks++;
            if (lat != LAT0 || busy != LAT0 || !idle_ok) begin
                errors++;
                $display("FAIL errors[%0d] timing: lat=%0d busy=%0d idle_after=%b, want lat=%0d busy=%0d", i, lat, busy, idle_ok, LAT0, LAT0);
            end
            checks++;
            if (o_err !== e.err || o_rd !== e.rdata) begin
                errors++;
                $display("FAIL errors[%0d] addr=%h resp: err=%b rdata=%h, want err=%b rdata=%h",
                         i, ta[i], o_err, o_rd, e.err, e.rdata);
            end
        end
    endtask

    task automatic test_random();
        int lat, busy; logic o_err, idle_ok; logic [31:0] o_rd; exp_t e;
        logic [31:0] a, wd; logic [3:0] b;
        for (int w = 8; w < 16; w++) begin
            run_txn(0, 1'b1, 32'(w * 4), 4'b1111, $urandom, lat, busy, o_err, o_rd, idle_ok);
            e = sb.pop_front();
        end
        for (int i = 0; i < 6; i++) begin
            a  = 32'($urandom_range(8, 15) * 4);
            b  = 4'($urandom_range(0, 15));
            wd = $urandom;
            run_txn(0, 1'b1, a, b, wd, lat, busy, o_err, o_rd, idle_ok);
            e = sb.pop_front();
            run_txn(0, 1'b0, a, 4'b0000, 32'h0, lat, busy, o_err, o_rd, idle_ok);
            e = sb.pop_front();
            checks++;
            if (lat != LAT0 || o_err !== e.err || o_rd !== e.rdata) begin
                errors++;
                $display("FAIL random[%0d] addr=%h be=%b: lat=%0d err=%b rdata=%h, want lat=%0d err=%b rdata=%h",
                         i, a, b, lat, o_err, o_rd, LAT0, e.err, e.rdata);
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat, busy, acks; logic o_err, idle_ok; logic [31:0] o_rd; exp_t e;
        run_txn(1, 1'b1, 32'h20, 4'b1111, 32'h0, lat, busy, o_err, o_rd, idle_ok);
        e = sb.pop_front();
        checks++;
        if (lat != LAT1 || busy != LAT1 || o_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid prewrite: lat=%0d busy=%0d err=%b, want lat=%0d busy=%0d err=0", lat, busy, o_err, LAT1, LAT1);
        end
        @(negedge clk);
        req_v[1] = 1'b1; we_v[1] = 1'b1; addr_v[1] = 32'h20; be_v[1] = 4'b1111; wdata_v[1] = 32'h12345678;
        @(negedge clk);
        req_v[1] = 1'b0;
        checks++;
        if (ready_v[1] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid busy: ready=%b, want 0", ready_v[1]);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (ready_v[1] !== 1'b1 || ack_v[1] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid abort: ready=%b ack=%b, want 1 0", ready_v[1], ack_v[1]);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ack_v[1] !== 1'b0) acks++;
        end
        checks++;
        if (acks != 0) begin
            errors++;
            $display("FAIL reset_mid no_ack: %0d acks after abort, want 0", acks);
        end
        run_txn(1, 1'b0, 32'h20, 4'b0000, 32'h0, lat, busy, o_err, o_rd, idle_ok);
        e = sb.pop_front();
        checks++;
        if (lat != LAT1 || o_err !== e.err || o_rd !== e.rdata) begin
            errors++;
            $display("FAIL reset_mid load: lat=%0d err=%b rdata=%h, want lat=%0d err=%b rdata=%h",
                     lat, o_err, o_rd, LAT1, e.err, e.rdata);
        end
    endtask

    task automatic test_back_to_back();
        int lat, busy, issued, acks; logic o_err, idle_ok; logic [31:0] o_rd; exp_t e;
        for (int w = 0; w < 5; w++) begin
            run_txn(2, 1'b1, 32'(w * 4), 4'b1111, 32'hA5A5_0000 + 32'(w * 17), lat, busy, o_err, o_rd, idle_ok);
            e = sb.pop_front();
            checks++;
            if (lat != LAT2 || busy != LAT2 || !idle_ok || o_err !== 1'b0) begin
                errors++;
                $display("FAIL b2b_prewrite[%0d]: lat=%0d busy=%0d idle_after=%b err=%b, want lat=%0d busy=%0d 1 0",
                         w, lat, busy, idle_ok, o_err, LAT2, LAT2);
            end
        end
        @(negedge clk);
        req_v[2] = 1'b1; we_v[2] = 1'b0; addr_v[2] = 32'h0; be_v[2] = 4'b0000; wdata_v[2] = 32'h0;
        push_exp(2, 1'b0, 32'h0, 4'b0000, 32'h0);
        issued = 1;
        acks   = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            checks++;
            if (ack_v[2] !== 1'(i % 2)) begin
                errors++;
                $display("FAIL b2b ack_cycle[%0d]: ack=%b, want %0d", i, ack_v[2], i % 2);
            end
            if (ack_v[2] === 1'b1) begin
                acks++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL b2b resp[%0d]: unexpected ack err=%b rdata=%h, want none", i, err_v[2], rdata_v[2]);
                end else begin
                    e = sb.pop_front();
                    if (err_v[2] !== e.err || rdata_v[2] !== e.rdata) begin
                        errors++;
                        $display("FAIL b2b resp[%0d]: err=%b rdata=%h, want err=%b rdata=%h",
                                 i, err_v[2], rdata_v[2], e.err, e.rdata);
                    end
                end
            end
            if (ready_v[2] === 1'b1 && issued < 5) begin
                we_v[2] = 1'b0; addr_v[2] = 32'(issued * 4); be_v[2] = 4'b0000; wdata_v[2] = 32'h0;
                push_exp(2, 1'b0, 32'(issued * 4), 4'b0000, 32'h0);
                issued++;
            end else if (ready_v[2] === 1'b1) begin
                req_v[2] = 1'b0;
            end else begin
                // Garbage that would err or corrupt if sampled outside IDLE
                we_v[2] = 1'b1; addr_v[2] = 32'h0000_0003; be_v[2] = 4'b1111; wdata_v[2] = 32'hFFFF_FFFF;
            end
        end
        req_v[2] = 1'b0;
        checks++;
        if (acks != 5 || sb.size() != 0) begin
            errors++;
            $display("FAIL b2b count: acks=%0d pending=%0d, want acks=5 pending=0", acks, sb.size());
        end
        sb.delete();
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            req_v[d] = 1'b0; we_v[d] = 1'b0; addr_v[d] = '0; be_v[d] = '0; wdata_v[d] = '0;
        end
        test_reset();
        test_latency_data();
        test_byte_enables();
        test_errors();
        test_random();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
